// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: named mode constant sets and small helpers
// used by the timing generator and its alignment delay line.
package vga_pkg;

  typedef struct packed {
    int h_sync;
    int h_back;
    int h_active;
    int h_front;
    int v_sync;
    int v_back;
    int v_active;
    int v_front;
  } vga_timing_t;

  localparam vga_timing_t VGA_1280X1024_60 = '{
    h_sync: 112, h_back: 248, h_active: 1280, h_front: 48,
    v_sync: 3,   v_back: 38,  v_active: 1024, v_front: 1
  };

  localparam vga_timing_t VGA_640X480_60 = '{
    h_sync: 96, h_back: 48, h_active: 640, h_front: 16,
    v_sync: 2,  v_back: 33, v_active: 480, v_front: 10
  };

  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 4;

  function automatic int span_total(input int sync_w, input int back_w,
                                    input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with asynchronous active-low clear; aligns
// sync and data-enable flags with the pixel-source read latency.
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, pixel requests, and sync/de/colour
// outputs aligned to a pixel source with PIPE enabled cycles of read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = VGA_1280X1024_60.h_sync,
  parameter int H_BACK   = VGA_1280X1024_60.h_back,
  parameter int H_ACTIVE = VGA_1280X1024_60.h_active,
  parameter int H_FRONT  = VGA_1280X1024_60.h_front,
  parameter int V_SYNC   = VGA_1280X1024_60.v_sync,
  parameter int V_BACK   = VGA_1280X1024_60.v_back,
  parameter int V_ACTIVE = VGA_1280X1024_60.v_active,
  parameter int V_FRONT  = VGA_1280X1024_60.v_front,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE     = 2,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic             req_valid,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  input  logic [11:0]      pix_rgb,
  output logic [3:0]       O_red,
  output logic [3:0]       O_green,
  output logic [3:0]       O_blue,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = span_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = span_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam longint CNT_RANGE = longint'(1) << CNT_W;

  if (longint'(H_TOTAL) > CNT_RANGE) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (longint'(V_TOTAL) > CNT_RANGE) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIPE < PIPE_MIN || PIPE > PIPE_MAX) begin : g_pipe_chk
    $error("vga_timing_gen: PIPE must be within 1..4");
  end

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   ext_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ORG    = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t V_ORG    = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ext_t H_ACT_LO = ext_t'(H_SYNC + H_BACK);
  localparam ext_t H_ACT_HI = ext_t'(H_SYNC + H_BACK + H_ACTIVE);
  localparam ext_t V_ACT_LO = ext_t'(V_SYNC + V_BACK);
  localparam ext_t V_ACT_HI = ext_t'(V_SYNC + V_BACK + V_ACTIVE);
  localparam ext_t H_SYNC_E = ext_t'(H_SYNC);
  localparam ext_t V_SYNC_E = ext_t'(V_SYNC);

  cnt_t        h_cnt_q, h_cnt_d;
  cnt_t        v_cnt_q, v_cnt_d;
  ext_t        h_ext, v_ext;
  logic        h_vis, v_vis, hsync_on, vsync_on;
  logic [2:0]  align_out;
  logic        hs_p, vs_p, de_p;
  logic        hs_on_q, hs_on_d, vs_on_q, vs_on_d, de_q, de_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
      end else begin
        h_cnt_d = h_cnt_q + CNT_ONE;
      end
    end
  end

  // Counters compared one bit wider so an active region ending exactly at
  // 2^CNT_W still has a representable exclusive upper bound.
  assign h_ext    = {1'b0, h_cnt_q};
  assign v_ext    = {1'b0, v_cnt_q};
  assign h_vis    = (h_ext >= H_ACT_LO) && (h_ext < H_ACT_HI);
  assign v_vis    = (v_ext >= V_ACT_LO) && (v_ext < V_ACT_HI);
  assign hsync_on = h_ext < H_SYNC_E;
  assign vsync_on = v_ext < V_SYNC_E;

  // req_valid is a pure valid with no ready: the pixel source cannot stall and
  // must present the matching pix_rgb exactly PIPE enabled cycles later.
  assign req_valid   = rst && h_vis && v_vis;
  assign req_x       = req_valid ? (h_cnt_q - H_ORG) : '0;
  assign req_y       = req_valid ? (v_cnt_q - V_ORG) : '0;
  assign line_start  = rst && ce && (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);

  vga_delay_line #(
    .W     (3),
    .DEPTH (PIPE)
  ) u_align (
    .clk   (clk),
    .rst_n (rst),
    .ce    (ce),
    .din   ({hsync_on, vsync_on, req_valid}),
    .dout  (align_out)
  );

  assign {hs_p, vs_p, de_p} = align_out;

  // Final stage: the PIPE-delayed request flag gates the returning pixel,
  // giving PIPE+1 total latency for colour and control alike.
  always_comb begin
    hs_on_d = hs_on_q;
    vs_on_d = vs_on_q;
    de_d    = de_q;
    rgb_d   = rgb_q;
    if (ce) begin
      hs_on_d = hs_p;
      vs_on_d = vs_p;
      de_d    = de_p;
      rgb_d   = de_p ? pix_rgb : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_on_q <= 1'b0;
      vs_on_q <= 1'b0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_on_q <= hs_on_d;
      vs_on_q <= vs_on_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hs      = hs_on_q ? SYNC_POL : ~SYNC_POL;
  assign vs      = vs_on_q ? SYNC_POL : ~SYNC_POL;
  assign de      = de_q;
  assign O_red   = rgb_q[11:8];
  assign O_green = rgb_q[7:4];
  assign O_blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster: directed table, ce patterns,
// random ce and mid-frame reset, checked against a position-arithmetic model.
module tb_vga_timing_gen;

  localparam int HS = 2, HB = 3, HA = 8, HF = 1;
  localparam int VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int PIPE = 2;
  localparam int LAT = PIPE + 1;
  localparam int CNT_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b0;
  logic [11:0] pix_rgb = '0;

  logic req_valid, hs, vs, de, fs, ls;
  logic [CNT_W-1:0] req_x, req_y;
  logic [3:0] o_r, o_g, o_b;
  logic req_valid_p, hs_p, vs_p, de_p, fs_p, ls_p;
  logic [CNT_W-1:0] req_x_p, req_y_p;
  logic [3:0] o_r_p, o_g_p, o_b_p;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n = 0;
  int cyc_since = 0;
  int req_since = 0;
  int exp_period = FRAME;
  bit fs_seen = 1'b0;

  typedef struct {
    int n;
    bit v;
    int x;
    int y;
    bit fs;
    bit ls;
    bit de;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(1'b0), .PIPE(PIPE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .pix_rgb(pix_rgb),
    .O_red(o_r), .O_green(o_g), .O_blue(o_b),
    .hs(hs), .vs(vs), .de(de), .frame_start(fs), .line_start(ls)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(1'b1), .PIPE(PIPE), .CNT_W(CNT_W)
  ) dut_p (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid_p), .req_x(req_x_p), .req_y(req_y_p), .pix_rgb(pix_rgb),
    .O_red(o_r_p), .O_green(o_g_p), .O_blue(o_b_p),
    .hs(hs_p), .vs(vs_p), .de(de_p), .frame_start(fs_p), .line_start(ls_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s n=%0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // Raster position m (enabled cycles since reset) -> visible request.
  function automatic void pos(input int m, output bit v, output int x, output int y);
    int h, l;
    h = m % HT;
    l = (m / HT) % VT;
    v = (h >= HS + HB) && (h < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
    x = v ? h - (HS + HB) : 0;
    y = v ? l - (VS + VB) : 0;
  endfunction

  function automatic logic [11:0] pix_word(input int x, input int y);
    logic [3:0] xr, yr;
    xr = 4'(x);
    yr = 4'(y);
    return {xr, yr, 4'hA};
  endfunction

  task automatic model_check();
    bit v, ov, efs, els, ehs, evs;
    int x, y, ox, oy, h, l;
    logic [11:0] ergb;
    v = 0; x = 0; y = 0; ov = 0; ox = 0; oy = 0;
    efs = 0; els = 0; ehs = 0; evs = 0;
    if (rst) begin
      pos(n, v, x, y);
      h = n % HT;
      l = (n / HT) % VT;
      efs = ce && h == 0 && l == 0;
      els = ce && h == 0;
      if (n >= LAT) begin
        pos(n - LAT, ov, ox, oy);
        ehs = ((n - LAT) % HT) < HS;
        evs = (((n - LAT) / HT) % VT) < VS;
      end
    end
    ergb = ov ? pix_word(ox, oy) : 12'h000;
    check("req", {7'b0, req_valid, req_x, req_y}, {7'b0, v, 12'(x), 12'(y)});
    check("pulse", {30'b0, fs, ls}, {30'b0, efs, els});
    check("out", {19'b0, de, o_r, o_g, o_b}, {19'b0, ov, ergb});
    check("sync", {30'b0, hs, vs}, {30'b0, ~ehs, ~evs});
    check("req_p", {5'b0, req_valid_p, fs_p, ls_p, req_x_p, req_y_p},
          {5'b0, v, efs, els, 12'(x), 12'(y)});
    check("out_p", {19'b0, de_p, o_r_p, o_g_p, o_b_p}, {19'b0, ov, ergb});
    check("sync_p", {30'b0, hs_p, vs_p}, {30'b0, ehs, evs});
  endtask

  // Pixel source: returns the word for the request made PIPE enabled cycles
  // earlier, noise when there was no request.
  task automatic drive(input bit ce_v);
    bit pv;
    int px, py;
    @(negedge clk);
    ce = ce_v;
    pv = 0; px = 0; py = 0;
    if (rst && n >= PIPE) pos(n - PIPE, pv, px, py);
    pix_rgb = pv ? pix_word(px, py) : 12'($urandom_range(0, 4095));
    #1;
  endtask

  task automatic advance();
    if (rst) begin
      cyc_since++;
      if (ce && req_valid) req_since++;
      if (fs) begin
        if (fs_seen) begin
          if (exp_period != 0) check("period", cyc_since, exp_period);
          check("reqs_per_frame", req_since, HA * VA);
        end
        fs_seen = 1'b1;
        cyc_since = 0;
        req_since = 0;
      end
    end else begin
      fs_seen = 1'b0;
    end
    @(posedge clk);
    if (!rst) n = 0;
    else if (ce) n++;
  endtask

  task automatic tick(input bit ce_v);
    drive(ce_v);
    model_check();
    advance();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    n = 0;
  endtask

  initial begin
    tbl[0]  = '{0,  1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[1]  = '{5,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[2]  = '{33, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[3]  = '{40, 1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 12'h40A};
    tbl[4]  = '{41, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 12'h50A};
    tbl[5]  = '{42, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h60A};
    tbl[6]  = '{82, 1'b1, 7, 3, 1'b0, 1'b0, 1'b1, 12'h43A};
    tbl[7]  = '{85, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 12'h73A};
    tbl[8]  = '{86, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[9]  = '{89, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[10] = '{98, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 12'h000};

    // Power-on reset with random ce: outputs must sit at reset values.
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
    release_reset();

    // Directed positions across the first frame and the wrap into the second.
    exp_period = FRAME;
    for (int i = 0; i < 11; i++) begin
      while (n < tbl[i].n) tick(1'b1);
      drive(1'b1);
      check("tbl_req", {7'b0, req_valid, req_x, req_y},
            {7'b0, tbl[i].v, 12'(tbl[i].x), 12'(tbl[i].y)});
      check("tbl_pulse", {30'b0, fs, ls}, {30'b0, tbl[i].fs, tbl[i].ls});
      check("tbl_out", {19'b0, de, o_r, o_g, o_b}, {19'b0, tbl[i].de, tbl[i].rgb});
      model_check();
      advance();
    end
    while (n < 3 * FRAME) tick(1'b1);

    // ce alternating 1,0: frame period doubles.
    fs_seen = 1'b0;
    exp_period = 2 * FRAME;
    for (int i = 0; i < 700; i++) tick(1'(i % 2 == 0));

    // Random ce: outputs must track the enabled-cycle position only.
    fs_seen = 1'b0;
    exp_period = 0;
    for (int i = 0; i < 1500; i++) tick(1'($urandom_range(0, 1)));

    // Asynchronous reset asserted at h=9, v=3, then released mid-frame.
    fs_seen = 1'b0;
    exp_period = FRAME;
    while ((n % FRAME) != 3 * HT + 9) tick(1'b1);
    drive(1'b1);
    model_check();
    rst = 1'b0;
    #1;
    check("rst_imm", {23'b0, req_valid, fs, ls, de, o_r, o_g, o_b, hs, vs},
          {23'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1});
    check("rst_imm_p", {30'b0, hs_p, vs_p}, {30'b0, 1'b0, 1'b0});
    model_check();
    advance();
    for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)));
    release_reset();
    drive(1'b1);
    check("fs_after_rst", {31'b0, fs}, {31'b0, 1'b1});
    model_check();
    advance();
    while (n < 2 * FRAME + 10) tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
